// File: rtl/exception_ctrl.sv
// Exception entry sequencer for the multicycle MIPS datapath: saves EPC, fetches the
// handler byte from the vector table and loads it into the PC through the PC-source mux.
module exception_ctrl #(
    parameter int MEM_LATENCY = 2,
    parameter int VEC_OPCODE  = 253,
    parameter int VEC_DIV0    = 254,
    parameter int VEC_OVF     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic [1:0]  exc_cause,
    input  logic [31:0] pc_in,
    input  logic [7:0]  mem_data_in,
    output logic        busy,
    output logic [31:0] epc_out,
    output logic        epc_write,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic [2:0]  pc_src_sel,
    output logic [31:0] pc_data,
    output logic        pc_write,
    output logic        done
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MEM_LATENCY - 1);
    localparam logic [2:0] SEL_MEM_DATA = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        SAVE_EPC,
        MEM_WAIT,
        LOAD_PC,
        DONE_ST
    } state_t;

    state_t           state, next_state;
    logic [1:0]       cause_q;
    logic [CNT_W-1:0] cnt;

    // Unused cause encoding 2'b11 falls back to the invalid-opcode vector.
    function automatic logic [31:0] vector_addr(input logic [1:0] cause);
        case (cause)
            2'b01:   vector_addr = 32'(VEC_OVF);
            2'b10:   vector_addr = 32'(VEC_DIV0);
            default: vector_addr = 32'(VEC_OPCODE);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cause_q  <= 2'b00;
            cnt      <= '0;
            epc_out  <= 32'd0;
            mem_addr <= 32'd0;
            pc_data  <= 32'd0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    // EPC is loaded on the accept edge so it is already valid while epc_write is high.
                    if (exc_valid) begin
                        cause_q <= exc_cause;
                        epc_out <= pc_in - 32'd4;
                    end
                end
                SAVE_EPC: begin
                    mem_addr <= vector_addr(cause_q);
                    cnt      <= CNT_START;
                end
                MEM_WAIT: begin
                    if (cnt == '0) begin
                        pc_data <= {24'b0, mem_data_in};
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        epc_write  = 1'b0;
        mem_rd     = 1'b0;
        pc_src_sel = 3'b000;
        pc_write   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (exc_valid) next_state = SAVE_EPC;
            end
            SAVE_EPC: begin
                busy       = 1'b1;
                epc_write  = 1'b1;
                next_state = MEM_WAIT;
            end
            MEM_WAIT: begin
                busy   = 1'b1;
                mem_rd = 1'b1;
                if (cnt == '0) next_state = LOAD_PC;
            end
            LOAD_PC: begin
                busy       = 1'b1;
                pc_src_sel = SEL_MEM_DATA;
                pc_write   = 1'b1;
                next_state = DONE_ST;
            end
            DONE_ST: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl with a vector-table memory that returns data
// only in the last cycle of a MEM_LATENCY-long read.
module tb_exception_ctrl;

    localparam int MEM_LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] pc_in;
    logic [7:0]  mem_data_in;
    logic        busy;
    logic [31:0] epc_out;
    logic        epc_write;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [2:0]  pc_src_sel;
    logic [31:0] pc_data;
    logic        pc_write;
    logic        done;

    int tests  = 0;
    int failed = 0;

    logic [7:0] mem [0:255];
    int         rd_cnt = 0;

    exception_ctrl #(
        .MEM_LATENCY(MEM_LATENCY),
        .VEC_OPCODE (253),
        .VEC_DIV0   (254),
        .VEC_OVF    (255)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .exc_valid  (exc_valid),
        .exc_cause  (exc_cause),
        .pc_in      (pc_in),
        .mem_data_in(mem_data_in),
        .busy       (busy),
        .epc_out    (epc_out),
        .epc_write  (epc_write),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .pc_src_sel (pc_src_sel),
        .pc_data    (pc_data),
        .pc_write   (pc_write),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) rd_cnt <= rd_cnt + 1;
        else        rd_cnt <= 0;
    end

    // Data is only valid on the final read cycle; anything earlier returns a poison byte.
    assign mem_data_in = (mem_rd && rd_cnt == MEM_LATENCY - 1) ? mem[mem_addr[7:0]] : 8'hEE;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"},   32'(busy),       32'd0);
        chk({tag, "_epc"},    epc_out,         32'd0);
        chk({tag, "_epcw"},   32'(epc_write),  32'd0);
        chk({tag, "_addr"},   mem_addr,        32'd0);
        chk({tag, "_rd"},     32'(mem_rd),     32'd0);
        chk({tag, "_sel"},    32'(pc_src_sel), 32'd0);
        chk({tag, "_pcdata"}, pc_data,         32'd0);
        chk({tag, "_pcw"},    32'(pc_write),   32'd0);
        chk({tag, "_done"},   32'(done),       32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_pcw;
        int n_done;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[253] = 8'hFF;
        mem[254] = 8'h77;
        mem[255] = 8'h40;

        reset = 1'b1; exc_valid = 1'b0; exc_cause = 2'b00; pc_in = 32'd0;
        tick();
        tick();
        chk_idle_zero("reset");
        reset = 1'b0;
        tick();

        // Overflow: pc 0x108 -> EPC 0x104, vector 255, handler 0x40
        exc_valid = 1'b1; exc_cause = 2'b01; pc_in = 32'h0000_0108;
        tick();
        exc_valid = 1'b0;
        chk("ovf_save_busy", 32'(busy),      32'd1);
        chk("ovf_save_epcw", 32'(epc_write), 32'd1);
        chk("ovf_save_epc",  epc_out,        32'h0000_0104);
        chk("ovf_save_rd",   32'(mem_rd),    32'd0);
        tick();
        chk("ovf_wait1_rd",   32'(mem_rd),    32'd1);
        chk("ovf_wait1_addr", mem_addr,       32'd255);
        chk("ovf_wait1_epcw", 32'(epc_write), 32'd0);
        tick();
        chk("ovf_wait2_rd",  32'(mem_rd),   32'd1);
        chk("ovf_wait2_pcw", 32'(pc_write), 32'd0);
        tick();
        chk("ovf_load_pcw",  32'(pc_write),   32'd1);
        chk("ovf_load_sel",  32'(pc_src_sel), 32'd5);
        chk("ovf_load_data", pc_data,         32'h0000_0040);
        chk("ovf_load_rd",   32'(mem_rd),     32'd0);
        tick();
        chk("ovf_done_done", 32'(done),     32'd1);
        chk("ovf_done_busy", 32'(busy),     32'd1);
        chk("ovf_done_pcw",  32'(pc_write), 32'd0);
        tick();
        chk("ovf_idle_busy", 32'(busy),       32'd0);
        chk("ovf_idle_done", 32'(done),       32'd0);
        chk("ovf_idle_sel",  32'(pc_src_sel), 32'd0);
        chk("ovf_hold_epc",  epc_out,         32'h0000_0104);
        chk("ovf_hold_data", pc_data,         32'h0000_0040);

        // Back-to-back accept in the cycle after done: div0 with pc 0 wraps EPC
        exc_valid = 1'b1; exc_cause = 2'b10; pc_in = 32'd0;
        tick();
        exc_valid = 1'b0;
        chk("div0_epc",  epc_out,        32'hFFFF_FFFC);
        chk("div0_epcw", 32'(epc_write), 32'd1);
        tick();
        chk("div0_addr", mem_addr, 32'd254);
        // Second request during MEM_WAIT must be dropped
        exc_valid = 1'b1; exc_cause = 2'b01; pc_in = 32'h0000_0500;
        tick();
        exc_valid = 1'b0;
        n_pcw = 0; n_done = 0;
        for (int c = 0; c < 10; c++) begin
            if (pc_write) begin
                n_pcw++;
                chk("div0_pcdata", pc_data, 32'h0000_0077);
            end
            if (done) n_done++;
            tick();
        end
        chk("div0_one_pcw",  32'(n_pcw),  32'd1);
        chk("div0_one_done", 32'(n_done), 32'd1);
        chk("div0_epc_kept", epc_out,     32'hFFFF_FFFC);
        chk("div0_end_busy", 32'(busy),   32'd0);

        // Cause 2'b11 uses the invalid-opcode vector
        exc_valid = 1'b1; exc_cause = 2'b11; pc_in = 32'h0000_2000;
        tick();
        exc_valid = 1'b0;
        chk("c11_epc", epc_out, 32'h0000_1FFC);
        tick();
        chk("c11_addr", mem_addr, 32'd253);
        tick();
        tick();
        chk("c11_pcw",    32'(pc_write), 32'd1);
        chk("c11_pcdata", pc_data,       32'h0000_00FF);
        tick();
        tick();

        // Reset in MEM_WAIT aborts with everything cleared and no later strobes
        exc_valid = 1'b1; exc_cause = 2'b01; pc_in = 32'h0000_0300;
        tick();
        exc_valid = 1'b0;
        tick();
        chk("rst_mid_rd", 32'(mem_rd), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle_zero("rst_mid");
        n_pcw = 0;
        for (int c = 0; c < 6; c++) begin
            if (pc_write || done || busy) n_pcw++;
            tick();
        end
        chk("rst_mid_no_activity", 32'(n_pcw), 32'd0);

        // Reset wins over a simultaneous request
        reset = 1'b1; exc_valid = 1'b1; exc_cause = 2'b10; pc_in = 32'h0000_0444;
        tick();
        reset = 1'b0; exc_valid = 1'b0;
        chk("rst_win_busy", 32'(busy),      32'd0);
        chk("rst_win_epc",  epc_out,        32'd0);
        tick();
        chk("rst_win_busy2", 32'(busy),      32'd0);
        chk("rst_win_epcw",  32'(epc_write), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
